fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 12'h000, first instruction word address fetched after reset.
REQ-002 clock  input  1  master clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = asserted).
REQ-004 address_imem  output  12  registered word address presented to imem (synchronous read, 1-cycle latency).
REQ-005 q_imem  input  32  instruction word for the address sampled by imem at the previous rising edge.
REQ-006 redirect  input  1  taken branch/jump from the processor; one-cycle pulse.
REQ-007 redirect_pc  input  12  target word address, qualified by redirect.
REQ-008 out_valid  output  1  out_insn/out_pc hold a valid instruction.
REQ-009 out_ready  input  1  consumer accepts; transfer when out_valid && out_ready at a rising edge.
REQ-010 out_insn  output  32  instruction word.
REQ-011 out_pc  output  12  word address of out_insn.

Function
REQ-012 The block SHALL hold a fetch PC register driving address_imem directly; word-addressed, increment +1 modulo 4096 (12'hFFF wraps to 12'h000).
REQ-013 An issue SHALL occur on an edge when buffered entries + in-flight requests < 2 and redirect is low; the PC then advances.
REQ-014 An in-flight request SHALL be captured from q_imem with its PC into a 2-entry FIFO on the following edge.
REQ-015 out_valid/out_insn/out_pc SHALL present the FIFO head; zero-bubble throughput of 1 instruction/cycle while out_ready is high.
REQ-016 With out_ready low, no instruction SHALL be dropped or duplicated; issue stops once the FIFO plus in-flight reaches 2.
REQ-017 FIFO pointers SHALL wrap at 2; a simultaneous pop and push at full SHALL keep occupancy constant.
REQ-018 On redirect: PC loads redirect_pc, the in-flight request is discarded, FIFO is emptied, out_valid is low the next cycle; first target instruction reaches out_valid 2 edges after the redirect edge.
REQ-019 A handshake on the same edge as redirect SHALL complete (the consumed instruction counts); all other entries are flushed.
REQ-020 Back-to-back redirects SHALL each take effect; the last one wins.
REQ-021 out_insn/out_pc SHALL hold stable while out_valid && !out_ready.

Reset
REQ-022 While reset is low: address_imem = RESET_PC, out_valid = 0, out_insn = 0, out_pc = 0, FIFO empty, no in-flight request.
REQ-023 The first issue SHALL occur at the first rising edge after reset deasserts; out_valid SHALL first rise after the second.
REQ-024 Reset asserted mid-operation SHALL discard all in-flight and buffered instructions immediately.

Configuration
REQ-025 With FETCH_PERF_EN defined: 32-bit output stall_cycles SHALL count edges with out_valid && !out_ready, saturate at 32'hFFFFFFFF, and clear on reset.
REQ-026 Without FETCH_PERF_EN: the port and counter are absent; all other behaviour is identical.

Verification
REQ-027 Reset release, RESET_PC=0, out_ready=1, imem word n = n+100 -> out_valid after 2nd edge, then out_pc 0,1,2,... with out_insn 100,101,102,... one per cycle.
REQ-028 out_ready low 5 cycles mid-stream -> no address_imem change after 2 issues, out_insn held, resumes without loss or duplicate; stall_cycles = 5 (FETCH_PERF_EN).
REQ-029 redirect=1, redirect_pc=12'h040 while streaming -> out_valid low next cycle, next out_pc = 12'h040 exactly 2 edges after redirect.
REQ-030 redirect on an edge with out_valid && out_ready for out_pc=7 -> pc 7 consumed once, pc 8 never appears, next out_pc = target.
REQ-031 RESET_PC=12'hFFE, out_ready=1 -> out_pc sequence FFE, FFF, 000, 001.
REQ-032 reset pulsed low mid-stream with FIFO full -> out_valid 0 immediately, restart from RESET_PC per REQ-023.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: the instruction-memory request/response pair, the redirect input
// and the instruction output handshake toward the decoder.
interface fetch_if;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;

  logic [AW-1:0] address_imem;
  logic [DW-1:0] q_imem;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_insn;
  logic [AW-1:0] out_pc;

  modport master (
    output address_imem,
    input  q_imem,
    input  redirect,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_insn,
    output out_pc
  );

  modport slave (
    input  address_imem,
    output q_imem,
    output redirect,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_insn,
    input  out_pc
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: a word-address PC feeding a 1-cycle-latency imem, plus a 2-entry
// skid FIFO. Define FETCH_PERF_EN to add the saturating stall_cycles counter port.
module fetch_stage #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic         clock,
  input  logic         reset,
  fetch_if.master      bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  stall_cycles
`endif
);

  localparam int unsigned AW    = 12;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 2;

  logic [AW-1:0] r_pc;
  logic          r_inflight;
  logic [AW-1:0] r_inflight_pc;
  logic [DW-1:0] r_mem_insn [DEPTH];
  logic [AW-1:0] r_mem_pc   [DEPTH];
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_count;
  logic          r_out_valid;
  logic [DW-1:0] r_out_insn;
  logic [AW-1:0] r_out_pc;

  logic          w_pop;
  logic          w_push;
  logic [1:0]    w_kept;
  logic [2:0]    w_occ;
  logic          w_issue;
  logic [AW-1:0] w_pc_nxt;
  logic          w_inflight_nxt;
  logic [AW-1:0] w_inflight_pc_nxt;
  logic          w_wr_nxt;
  logic          w_rd_nxt;
  logic [1:0]    w_count_nxt;
  logic [DW-1:0] w_head_insn;
  logic [AW-1:0] w_head_pc;

  // The pop is counted before the issue decision so a draining consumer sees no bubble.
  assign w_pop   = r_out_valid && bus.out_ready;
  assign w_push  = r_inflight && !bus.redirect;
  assign w_kept  = r_count - {1'b0, w_pop};
  assign w_occ   = {1'b0, w_kept} + {2'b00, r_inflight};
  assign w_issue = !bus.redirect && (w_occ < 3'd2);

  // Next-state for PC, in-flight tracker, FIFO pointers and the registered FIFO head.
  always_comb begin
    w_pc_nxt          = r_pc;
    w_inflight_nxt    = r_inflight;
    w_inflight_pc_nxt = r_inflight_pc;
    w_wr_nxt          = r_wr_ptr;
    w_rd_nxt          = r_rd_ptr;
    w_count_nxt       = r_count;
    w_head_insn       = r_out_insn;
    w_head_pc         = r_out_pc;

    if (bus.redirect) begin
      w_pc_nxt       = bus.redirect_pc;
      w_inflight_nxt = 1'b0;
      w_wr_nxt       = 1'b0;
      w_rd_nxt       = 1'b0;
      w_count_nxt    = 2'd0;
    end else begin
      w_rd_nxt       = r_rd_ptr ^ w_pop;
      w_wr_nxt       = r_wr_ptr ^ w_push;
      w_count_nxt    = w_kept + {1'b0, w_push};
      w_inflight_nxt = w_issue;
      if (w_issue) begin
        w_inflight_pc_nxt = r_pc;
        w_pc_nxt          = r_pc + AW'(1);
      end
      // An entry written this edge into an otherwise empty FIFO becomes the head directly.
      if (w_count_nxt != 2'd0) begin
        if (w_push && (r_wr_ptr == w_rd_nxt)) begin
          w_head_insn = bus.q_imem;
          w_head_pc   = r_inflight_pc;
        end else begin
          w_head_insn = r_mem_insn[w_rd_nxt];
          w_head_pc   = r_mem_pc[w_rd_nxt];
        end
      end
    end
  end

  // Fetch PC and in-flight request tracking.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_pc          <= w_pc_nxt;
      r_inflight    <= w_inflight_nxt;
      r_inflight_pc <= w_inflight_pc_nxt;
    end
  end

  // FIFO storage and pointers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem_insn[i] <= '0;
        r_mem_pc[i]   <= '0;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem_insn[r_wr_ptr] <= bus.q_imem;
        r_mem_pc[r_wr_ptr]   <= r_inflight_pc;
      end
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_count_nxt;
    end
  end

  // Registered copy of the FIFO head drives the consumer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_insn  <= '0;
      r_out_pc    <= '0;
    end else begin
      r_out_valid <= (w_count_nxt != 2'd0);
      r_out_insn  <= w_head_insn;
      r_out_pc    <= w_head_pc;
    end
  end

  assign bus.address_imem = r_pc;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_insn     = r_out_insn;
  assign bus.out_pc       = r_out_pc;

`ifdef FETCH_PERF_EN
  logic [31:0] r_stall_cycles;

  // Saturating count of edges where a valid instruction is held back by the consumer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stall_cycles <= '0;
    end else if (r_out_valid && !bus.out_ready && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: scoreboard of expected (pc, insn) pairs popped on every
// handshake, plus point checks for reset, stall, redirect, wrap and mid-stream reset.
module tb_fetch_stage;

  typedef struct packed {
    logic [11:0] pc;
    logic [31:0] insn;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  fetch_if bus1 ();
  fetch_if bus2 ();

`ifdef FETCH_PERF_EN
  logic [31:0] stall1;
  logic [31:0] stall2;
`endif

  fetch_stage #(.RESET_PC(12'h000)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
`ifdef FETCH_PERF_EN
    ,
    .stall_cycles (stall1)
`endif
  );

  fetch_stage #(.RESET_PC(12'hFFE)) u_dut_wrap (
    .clock (clock),
    .reset (reset),
    .bus   (bus2)
`ifdef FETCH_PERF_EN
    ,
    .stall_cycles (stall2)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] imem_word(input logic [11:0] a);
    return 32'(a) + 32'd100;
  endfunction

  // Synchronous-read instruction memories: word n holds n+100.
  always @(posedge clock) bus1.q_imem <= imem_word(bus1.address_imem);
  always @(posedge clock) bus2.q_imem <= imem_word(bus2.address_imem);

  exp_t q1[$];
  exp_t q2[$];
  int   n_err  = 0;
  int   n_chk  = 0;
  int   n_xfer = 0;
  int   xfer_mark;
  bit   en2    = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push1(input logic [11:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      logic [11:0] p;
      p = start + 12'(i);
      q1.push_back('{pc: p, insn: imem_word(p)});
    end
  endtask

  task automatic push2(input logic [11:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      logic [11:0] p;
      p = start + 12'(i);
      q2.push_back('{pc: p, insn: imem_word(p)});
    end
  endtask

  // One clock: score any handshake seen before the edge, then return just after the edge.
  task automatic cycle();
    exp_t e;
    @(negedge clock);
    if (bus1.out_valid && bus1.out_ready) begin
      n_chk++;
      assert (q1.size() > 0)
      else begin
        n_err++;
        $error("FAIL xfer_extra observed pc=%0h expected no transfer", bus1.out_pc);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("xfer_pc", 32'(bus1.out_pc), 32'(e.pc));
        check("xfer_insn", bus1.out_insn, e.insn);
      end
      n_xfer++;
    end
    if (en2 && bus2.out_valid && bus2.out_ready && (q2.size() > 0)) begin
      e = q2.pop_front();
      check("wrap_pc", 32'(bus2.out_pc), 32'(e.pc));
      check("wrap_insn", bus2.out_insn, e.insn);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    bus1.redirect    = 1'b0;
    bus1.redirect_pc = 12'h000;
    bus1.out_ready   = 1'b1;
    bus2.redirect    = 1'b0;
    bus2.redirect_pc = 12'h000;
    bus2.out_ready   = 1'b1;

    repeat (3) @(posedge clock);
    #1;
    check("rst_addr", 32'(bus1.address_imem), 32'h000);
    check("rst_valid", 32'(bus1.out_valid), 32'd0);
    check("rst_insn", bus1.out_insn, 32'd0);
    check("rst_pc", 32'(bus1.out_pc), 32'd0);
    check("rst_addr_wrap", 32'(bus2.address_imem), 32'hFFE);

    // Reset release and steady streaming
    push1(12'h000, 40);
    push2(12'hFFE, 40);
    en2   = 1'b1;
    reset = 1'b1;
    cycle();
    check("edge1_addr", 32'(bus1.address_imem), 32'h001);
    check("edge1_valid", 32'(bus1.out_valid), 32'd0);
    check("edge1_addr_wrap", 32'(bus2.address_imem), 32'hFFF);
    cycle();
    check("edge2_valid", 32'(bus1.out_valid), 32'd1);
    check("edge2_pc", 32'(bus1.out_pc), 32'h000);
    check("edge2_insn", bus1.out_insn, 32'd100);
    check("edge2_pc_wrap", 32'(bus2.out_pc), 32'hFFE);
    repeat (10) cycle();
    check("stream_xfers", 32'(n_xfer), 32'd10);
    check("stream_head", 32'(bus1.out_pc), 32'd10);
    check("wrap_head", 32'(bus2.out_pc), 32'h008);
    en2 = 1'b0;

    // Consumer stall for 5 edges
    bus1.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("stall_addr", 32'(bus1.address_imem), 32'd12);
      check("stall_valid", 32'(bus1.out_valid), 32'd1);
      check("stall_pc", 32'(bus1.out_pc), 32'd10);
      check("stall_insn", bus1.out_insn, 32'd110);
    end
`ifdef FETCH_PERF_EN
    check("stall_count", stall1, 32'd5);
`endif
    check("stall_xfers", 32'(n_xfer), 32'd10);
    bus1.out_ready = 1'b1;
    repeat (6) cycle();
    check("resume_xfers", 32'(n_xfer), 32'd16);
    check("resume_head", 32'(bus1.out_pc), 32'd16);

    // Redirect while streaming
    bus1.redirect    = 1'b1;
    bus1.redirect_pc = 12'h040;
    cycle();
    bus1.redirect = 1'b0;
    q1.delete();
    push1(12'h040, 8);
    check("redir_valid0", 32'(bus1.out_valid), 32'd0);
    check("redir_addr", 32'(bus1.address_imem), 32'h040);
    cycle();
    check("redir_valid1", 32'(bus1.out_valid), 32'd0);
    cycle();
    check("redir_valid2", 32'(bus1.out_valid), 32'd1);
    check("redir_pc", 32'(bus1.out_pc), 32'h040);
    check("redir_insn", bus1.out_insn, imem_word(12'h040));
    repeat (3) cycle();

    // Redirect on the same edge as the handshake of pc 7
    bus1.redirect    = 1'b1;
    bus1.redirect_pc = 12'h000;
    cycle();
    bus1.redirect = 1'b0;
    q1.delete();
    push1(12'h000, 8);
    repeat (2) cycle();
    check("r0_pc", 32'(bus1.out_pc), 32'h000);
    repeat (7) cycle();
    check("at7_pc", 32'(bus1.out_pc), 32'h007);
    check("at7_valid", 32'(bus1.out_valid), 32'd1);
    xfer_mark        = n_xfer;
    bus1.redirect    = 1'b1;
    bus1.redirect_pc = 12'h200;
    cycle();
    bus1.redirect = 1'b0;
    check("pc7_taken_once", 32'(n_xfer - xfer_mark), 32'd1);
    check("pc7_queue_drained", 32'(q1.size()), 32'd0);
    q1.delete();
    push1(12'h200, 8);
    cycle();
    check("r200_valid0", 32'(bus1.out_valid), 32'd0);
    cycle();
    check("r200_pc", 32'(bus1.out_pc), 32'h200);
    repeat (2) cycle();

    // Back-to-back redirects: last one wins
    bus1.redirect    = 1'b1;
    bus1.redirect_pc = 12'h100;
    cycle();
    bus1.redirect_pc = 12'h300;
    cycle();
    bus1.redirect = 1'b0;
    q1.delete();
    push1(12'h300, 8);
    check("b2b_addr", 32'(bus1.address_imem), 32'h300);
    check("b2b_valid", 32'(bus1.out_valid), 32'd0);
    repeat (2) cycle();
    check("b2b_pc", 32'(bus1.out_pc), 32'h300);
    repeat (2) cycle();

    // Reset mid-stream with the FIFO full
    bus1.out_ready = 1'b0;
    repeat (2) cycle();
    check("full_addr", 32'(bus1.address_imem), 32'h304);
    check("full_pc", 32'(bus1.out_pc), 32'h302);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus1.out_valid), 32'd0);
    check("mid_rst_addr", 32'(bus1.address_imem), 32'h000);
    check("mid_rst_pc", 32'(bus1.out_pc), 32'd0);
    check("mid_rst_insn", bus1.out_insn, 32'd0);
`ifdef FETCH_PERF_EN
    check("mid_rst_stall", stall1, 32'd0);
    check("wrap_stall", stall2, 32'd0);
`endif
    repeat (2) @(posedge clock);
    #1;
    q1.delete();
    push1(12'h000, 8);
    bus1.out_ready = 1'b1;
    reset          = 1'b1;
    cycle();
    check("restart_valid0", 32'(bus1.out_valid), 32'd0);
    check("restart_addr", 32'(bus1.address_imem), 32'h001);
    cycle();
    check("restart_valid", 32'(bus1.out_valid), 32'd1);
    check("restart_pc", 32'(bus1.out_pc), 32'h000);
    check("restart_insn", bus1.out_insn, 32'd100);
    repeat (4) cycle();
    check("restart_head", 32'(bus1.out_pc), 32'h004);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
